// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the nibble-serial ALU
//                sequencer: FSM state encoding, nibble width and the
//                74181 S-codes used by the control side.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  localparam int NIB_W = 4;

  // 74181 S-codes. SEL_SUB is used with M=0, SEL_XOR with M=1; the
  // encodings coincide because the 74181 shares one S-code between them.
  localparam logic [3:0] SEL_ADD = 4'b1001;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_XOR = 4'b0110;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_nibble_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_nibble_sequencer_if / alu_slice_if
//  Description : Bus bundles around the nibble sequencer.
//                alu_nibble_sequencer_if : request/response handshake between
//                  the control FSM (master) and the sequencer (slave).
//                alu_slice_if : nibble bus between the sequencer (master)
//                  and one 4-bit 74181 slice (slave).
//  Ports       : signal names keep the sequencer's point of view (_i = into
//                the sequencer, _o = out of the sequencer).
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_nibble_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [WIDTH-1:0] req_a_i;
  logic [WIDTH-1:0] req_b_i;
  logic [3:0]       req_sel_i;
  logic             req_mode_i;
  logic             req_carry_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WIDTH-1:0] rsp_f_o;
  logic             rsp_carry_o;
  logic             rsp_eq_o;

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_sel_i, req_mode_i, req_carry_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_f_o, rsp_carry_o, rsp_eq_o
  );

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_sel_i, req_mode_i, req_carry_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_f_o, rsp_carry_o, rsp_eq_o
  );
endinterface : alu_nibble_sequencer_if

interface alu_slice_if;
  logic [3:0] slice_a_o;
  logic [3:0] slice_b_o;
  logic [3:0] slice_sel_o;
  logic       slice_mode_o;
  logic       slice_carry_o;
  logic [3:0] slice_f_i;
  logic       slice_carry_i;
  logic       slice_eq_i;

  modport master (
    output slice_a_o, slice_b_o, slice_sel_o, slice_mode_o, slice_carry_o,
    input  slice_f_i, slice_carry_i, slice_eq_i
  );

  modport slave (
    input  slice_a_o, slice_b_o, slice_sel_o, slice_mode_o, slice_carry_o,
    output slice_f_i, slice_carry_i, slice_eq_i
  );
endinterface : alu_slice_if
`default_nettype wire

// File: rtl/alu_74181.sv
`default_nettype none
// ============================================================================
//  Module      : alu_74181
//  Description : Behavioural 4-bit 74181-compatible ALU slice, active-high
//                data. Carry in/out are active-high (cn=1 adds one).
//  Ports       : a, b   4   operands
//                s      4   function select
//                m      1   1 = logic, 0 = arithmetic
//                cn     1   carry in
//                f      4   result
//                cn4    1   carry out of the arithmetic sum
//                aeqb   1   high when f is all ones (74181 A=B output)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn,
  output logic [3:0] f,
  output logic       cn4,
  output logic       aeqb
);

  logic [3:0] w_p;
  logic [3:0] w_q;
  logic [3:0] w_logic;
  logic [4:0] w_sum;

  // Each arithmetic function is expressed as P + Q + cn; the "minus one"
  // functions use Q = 4'hF so the carry out behaves as on the real part.
  always_comb begin
    w_p = a;
    w_q = 4'h0;
    unique case (s)
      4'b0000: begin w_p = a;        w_q = 4'h0;    end
      4'b0001: begin w_p = a | b;    w_q = 4'h0;    end
      4'b0010: begin w_p = a | ~b;   w_q = 4'h0;    end
      4'b0011: begin w_p = 4'h0;     w_q = 4'hF;    end
      4'b0100: begin w_p = a;        w_q = a & ~b;  end
      4'b0101: begin w_p = a | b;    w_q = a & ~b;  end
      4'b0110: begin w_p = a;        w_q = ~b;      end
      4'b0111: begin w_p = a & ~b;   w_q = 4'hF;    end
      4'b1000: begin w_p = a;        w_q = a & b;   end
      4'b1001: begin w_p = a;        w_q = b;       end
      4'b1010: begin w_p = a | ~b;   w_q = a & b;   end
      4'b1011: begin w_p = a & b;    w_q = 4'hF;    end
      4'b1100: begin w_p = a;        w_q = a;       end
      4'b1101: begin w_p = a | b;    w_q = a;       end
      4'b1110: begin w_p = a | ~b;   w_q = a;       end
      default: begin w_p = a;        w_q = 4'hF;    end
    endcase
  end

  always_comb begin
    w_logic = a;
    unique case (s)
      4'b0000: w_logic = ~a;
      4'b0001: w_logic = ~(a | b);
      4'b0010: w_logic = ~a & b;
      4'b0011: w_logic = 4'h0;
      4'b0100: w_logic = ~(a & b);
      4'b0101: w_logic = ~b;
      4'b0110: w_logic = a ^ b;
      4'b0111: w_logic = a & ~b;
      4'b1000: w_logic = ~a | b;
      4'b1001: w_logic = ~(a ^ b);
      4'b1010: w_logic = b;
      4'b1011: w_logic = a & b;
      4'b1100: w_logic = 4'hF;
      4'b1101: w_logic = a | ~b;
      4'b1110: w_logic = a | b;
      default: w_logic = a;
    endcase
  end

  assign w_sum = {1'b0, w_p} + {1'b0, w_q} + {4'h0, cn};
  assign f     = m ? w_logic : w_sum[3:0];
  assign cn4   = w_sum[4];
  assign aeqb  = &f;

endmodule : alu_74181
`default_nettype wire

// File: rtl/alu_nibble_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_nibble_sequencer
//  Description : Runs WIDTH-bit operations on one external 4-bit 74181
//                slice, one nibble per cycle LSB first, rippling the carry
//                through a register. Result returned via valid/ready.
//  Ports       : clk_i      clock, rising edge
//                rst_i      synchronous active-high reset
//                req_bus    request/response handshake (slave side)
//                           req_valid/ready, req_a/b, req_sel, req_mode,
//                           req_carry, rsp_valid/ready, rsp_f, rsp_carry,
//                           rsp_eq
//                slice_bus  nibble bus to the slice (master side)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_nibble_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  alu_nibble_sequencer_if.slave   req_bus,
  alu_slice_if.master             slice_bus
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("alu_nibble_sequencer: WIDTH must be a multiple of 4 and >= 8");
  end

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_nib_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_sel;
  logic             r_mode;
  logic             r_carry;
  logic             r_eq;
  logic [WIDTH-1:0] r_result;

  logic [CNT_W+1:0] w_base;
  logic             w_last;
  logic             w_run;

  // Bit offset of the current nibble (nib_cnt * 4).
  assign w_base = {r_nib_cnt, 2'b00};
  assign w_last = (r_nib_cnt == CNT_W'(NIB - 1));
  assign w_run  = (r_state == ST_RUN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_nib_cnt <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sel     <= '0;
      r_mode    <= 1'b0;
      r_carry   <= 1'b0;
      r_eq      <= 1'b0;
      r_result  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (req_bus.req_valid_i) begin
            r_a       <= req_bus.req_a_i;
            r_b       <= req_bus.req_b_i;
            r_sel     <= req_bus.req_sel_i;
            r_mode    <= req_bus.req_mode_i;
            r_carry   <= req_bus.req_carry_i;
            r_nib_cnt <= '0;
            r_eq      <= 1'b1;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_result[w_base +: NIB_W] <= slice_bus.slice_f_i;
          r_eq                      <= r_eq & slice_bus.slice_eq_i;
          // Logic mode keeps the request carry in the register so every
          // nibble sees the same carry input.
          if (!r_mode) begin
            r_carry <= slice_bus.slice_carry_i;
          end
          if (w_last) begin
            r_state <= ST_DONE;
          end else begin
            r_nib_cnt <= r_nib_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (req_bus.rsp_ready_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_bus.req_ready_o = (r_state == ST_IDLE);
  assign req_bus.rsp_valid_o = (r_state == ST_DONE);
  assign req_bus.rsp_f_o     = r_result;
  assign req_bus.rsp_carry_o = r_carry & ~r_mode;
  assign req_bus.rsp_eq_o    = r_eq;

  assign slice_bus.slice_a_o     = w_run ? r_a[w_base +: NIB_W] : 4'h0;
  assign slice_bus.slice_b_o     = w_run ? r_b[w_base +: NIB_W] : 4'h0;
  assign slice_bus.slice_sel_o   = w_run ? r_sel : 4'h0;
  assign slice_bus.slice_mode_o  = w_run & r_mode;
  assign slice_bus.slice_carry_o = w_run & r_carry;

endmodule : alu_nibble_sequencer
`default_nettype wire

// File: tb/tb_alu_nibble_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_nibble_sequencer
//  Description : Directed self-checking bench for alu_nibble_sequencer
//                (WIDTH=16) driving a behavioural alu_74181 slice.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_nibble_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer_if #(.WIDTH(16)) req_bus ();
  alu_slice_if                          slice_bus ();

  alu_nibble_sequencer #(.WIDTH(16)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_bus   (req_bus.slave),
    .slice_bus (slice_bus.master)
  );

  alu_74181 u_slice (
    .a    (slice_bus.slice_a_o),
    .b    (slice_bus.slice_b_o),
    .s    (slice_bus.slice_sel_o),
    .m    (slice_bus.slice_mode_o),
    .cn   (slice_bus.slice_carry_o),
    .f    (slice_bus.slice_f_i),
    .cn4  (slice_bus.slice_carry_i),
    .aeqb (slice_bus.slice_eq_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with fixed-latency expectations and immediate
  // response handshake.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] sel, input logic mode, input logic cin,
                        input logic [15:0] exp_f, input logic exp_c, input logic exp_eq);
    req_bus.req_a_i     = a;
    req_bus.req_b_i     = b;
    req_bus.req_sel_i   = sel;
    req_bus.req_mode_i  = mode;
    req_bus.req_carry_i = cin;
    req_bus.req_valid_i = 1'b1;
    check({tag, ":req_ready"}, req_bus.req_ready_o, 1);
    tick();
    req_bus.req_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check({tag, ":valid_low"}, req_bus.rsp_valid_o, 0);
      check({tag, ":slice_a"}, slice_bus.slice_a_o, a[4*k +: 4]);
      if (k == 0 || mode) check({tag, ":slice_cin"}, slice_bus.slice_carry_o, cin);
      tick();
    end
    check({tag, ":valid"}, req_bus.rsp_valid_o, 1);
    check({tag, ":f"}, req_bus.rsp_f_o, exp_f);
    check({tag, ":carry"}, req_bus.rsp_carry_o, exp_c);
    check({tag, ":eq"}, req_bus.rsp_eq_o, exp_eq);
    check({tag, ":busy"}, req_bus.req_ready_o, 0);
    req_bus.rsp_ready_i = 1'b1;
    tick();
    req_bus.rsp_ready_i = 1'b0;
    check({tag, ":valid_drop"}, req_bus.rsp_valid_o, 0);
    check({tag, ":ready_back"}, req_bus.req_ready_o, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                 = 1'b1;
    req_bus.req_valid_i = 1'b0;
    req_bus.req_a_i     = '0;
    req_bus.req_b_i     = '0;
    req_bus.req_sel_i   = '0;
    req_bus.req_mode_i  = 1'b0;
    req_bus.req_carry_i = 1'b0;
    req_bus.rsp_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst:req_ready", req_bus.req_ready_o, 1);
    check("rst:rsp_valid", req_bus.rsp_valid_o, 0);
    check("rst:rsp_f", req_bus.rsp_f_o, 16'h0000);
    check("rst:rsp_carry", req_bus.rsp_carry_o, 0);
    check("rst:rsp_eq", req_bus.rsp_eq_o, 0);
    check("rst:slice_a", slice_bus.slice_a_o, 4'h0);
    check("rst:slice_sel", slice_bus.slice_sel_o, 4'h0);
    check("rst:slice_cin", slice_bus.slice_carry_o, 0);

    run_op("add",      16'h0FFF, 16'h0001, SEL_ADD, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("overflow", 16'hFFFF, 16'h0001, SEL_ADD, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("carry_in", 16'h1234, 16'h1111, SEL_ADD, 1'b0, 1'b1, 16'h2346, 1'b0, 1'b0);
    run_op("xor",      16'hF0F0, 16'hFF00, SEL_XOR, 1'b1, 1'b1, 16'h0FF0, 1'b0, 1'b0);
    run_op("sub_eq",   16'h5A5A, 16'h5A5A, SEL_SUB, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
    run_op("sub",      16'h1234, 16'h0234, SEL_SUB, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0);
    run_op("xor_ones", 16'hF0F0, 16'h0F0F, SEL_XOR, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1);

    // Backpressure with a queued request
    req_bus.req_a_i     = 16'h0003;
    req_bus.req_b_i     = 16'h0004;
    req_bus.req_sel_i   = SEL_ADD;
    req_bus.req_mode_i  = 1'b0;
    req_bus.req_carry_i = 1'b0;
    req_bus.req_valid_i = 1'b1;
    tick();
    req_bus.req_a_i = 16'h00F0;
    req_bus.req_b_i = 16'h0010;
    repeat (4) tick();
    check("bp:valid", req_bus.rsp_valid_o, 1);
    check("bp:f", req_bus.rsp_f_o, 16'h0007);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp:hold_valid", req_bus.rsp_valid_o, 1);
      check("bp:hold_f", req_bus.rsp_f_o, 16'h0007);
      check("bp:hold_carry", req_bus.rsp_carry_o, 0);
      check("bp:hold_busy", req_bus.req_ready_o, 0);
    end
    req_bus.rsp_ready_i = 1'b1;
    tick();
    req_bus.rsp_ready_i = 1'b0;
    check("bp:idle_ready", req_bus.req_ready_o, 1);
    check("bp:idle_valid", req_bus.rsp_valid_o, 0);
    tick();
    req_bus.req_valid_i = 1'b0;
    check("bp:accepted", req_bus.req_ready_o, 0);
    check("bp:q_slice_a", slice_bus.slice_a_o, 4'h0);
    repeat (4) tick();
    check("bp:q_valid", req_bus.rsp_valid_o, 1);
    check("bp:q_f", req_bus.rsp_f_o, 16'h0100);
    check("bp:q_carry", req_bus.rsp_carry_o, 0);
    req_bus.rsp_ready_i = 1'b1;
    tick();
    req_bus.rsp_ready_i = 1'b0;

    // Reset in the middle of an operation
    req_bus.req_a_i     = 16'h1234;
    req_bus.req_b_i     = 16'h1111;
    req_bus.req_sel_i   = SEL_ADD;
    req_bus.req_mode_i  = 1'b0;
    req_bus.req_carry_i = 1'b1;
    req_bus.req_valid_i = 1'b1;
    tick();
    req_bus.req_valid_i = 1'b0;
    tick();
    tick();
    check("mid:slice_a_nib2", slice_bus.slice_a_o, 4'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid:req_ready", req_bus.req_ready_o, 1);
    check("mid:rsp_f", req_bus.rsp_f_o, 16'h0000);
    check("mid:slice_a", slice_bus.slice_a_o, 4'h0);
    for (int i = 0; i < 5; i++) begin
      check("mid:no_valid", req_bus.rsp_valid_o, 0);
      tick();
    end
    run_op("post_rst", 16'h0001, 16'h0001, SEL_ADD, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_nibble_sequencer
`default_nettype wire
